// File: rtl/block_scanner.sv
// block_scanner: raster walker giving in-cell pixel coordinates and board-RAM colour per pixel.
// Define BOARD_BORDER_EN to treat a one-cell wall around the board as inside (grey, no RAM read).
module block_scanner #(
  parameter int CELL_W = 26,
  parameter int CELL_H = 32,
  parameter int COLS   = 10,
  parameter int ROWS   = 15,
  parameter int X0     = 190,
  parameter int Y0     = 0,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sof,
  input  logic          de,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [3:0]    rd_data,
  output logic [5:0]    block_x,
  output logic [5:0]    block_y,
  output logic [11:0]   cell_color,
  output logic          in_board,
  output logic          out_valid
);

`ifdef BOARD_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  localparam int XS_I  = BORDER ? X0 - CELL_W : X0;
  localparam int YS_I  = BORDER ? Y0 - CELL_H : Y0;
  localparam int XE_I  = X0 + COLS * CELL_W;
  localparam int YE_I  = Y0 + ROWS * CELL_H;
  localparam int XXE_I = BORDER ? XE_I + CELL_W : XE_I;
  localparam int YYE_I = BORDER ? YE_I + CELL_H : YE_I;
  localparam int XXS_I = (XS_I < 0) ? 0 : XS_I;
  localparam int YYS_I = (YS_I < 0) ? 0 : YS_I;

  localparam logic [10:0] X_LO    = 11'(X0);
  localparam logic [10:0] X_SPAN  = 11'(XE_I - X0);
  localparam logic [10:0] XX_LO   = 11'(XXS_I);
  localparam logic [10:0] XX_SPAN = 11'(XXE_I - XXS_I);
  localparam logic [9:0]  Y_LO    = 10'(Y0);
  localparam logic [9:0]  Y_SPAN  = 10'(YE_I - Y0);
  localparam logic [9:0]  YY_LO   = 10'(YYS_I);
  localparam logic [9:0]  YY_SPAN = 10'(YYE_I - YYS_I);

  // Phase of the cell counters when the wall starts off-screen (negative origin)
  localparam logic [5:0] BX_LD   = 6'((XS_I < 0) ? ((-XS_I) % CELL_W) : 0);
  localparam logic [5:0] BY_LD   = 6'((YS_I < 0) ? ((-YS_I) % CELL_H) : 0);
  localparam logic [5:0] BX_LAST = 6'(CELL_W - 1);
  localparam logic [5:0] BY_LAST = 6'(CELL_H - 1);

  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  typedef enum logic {ST_DISARMED, ST_ARMED} state_t;

  state_t        r_state, w_state_nxt;
  logic          w_armed, w_pix, w_fall;
  logic          r_de_prev;

  logic [10:0]   r_px, w_px;
  logic [9:0]    r_ln, w_ln, w_ln_nxt;
  logic [5:0]    r_bx, w_bx, w_bx_nxt;
  logic [5:0]    r_by, w_by;
  logic [AW-1:0] r_col, w_col, w_col_nxt;
  logic [AW-1:0] r_row, r_rowbase, w_rowbase, w_addr;
  logic          w_bx_wrap, w_in_x, w_in_y, w_ext_x, w_ext_y;
  logic          w_in_board, w_in_wall;
  logic          w_fy_board, w_fy_ext;

  logic          r_s1_valid, r_s1_board, r_s1_wall;
  logic [5:0]    r_s1_bx, r_s1_by;
  logic          r_s2_valid, r_s2_board, r_s2_wall;
  logic [5:0]    r_s2_bx, r_s2_by;
  logic [11:0]   w_map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_DISARMED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_armed     = (r_state == ST_ARMED);
    if (sof) w_state_nxt = ST_ARMED;
    w_pix  = de && (sof || w_armed);
    w_fall = w_armed && !sof && !de && r_de_prev;
  end

  // sof overrides the stored counters so a pixel coinciding with it sits at (0,0)
  always_comb begin
    w_px      = sof ? '0 : r_px;
    w_ln      = sof ? '0 : r_ln;
    w_by      = sof ? BY_LD : r_by;
    w_rowbase = sof ? '0 : r_rowbase;
    w_bx      = (w_px == XX_LO) ? BX_LD : r_bx;
    w_col     = (w_px == X_LO) ? '0 : r_col;
    w_in_x    = (w_px - X_LO) < X_SPAN;
    w_in_y    = (w_ln - Y_LO) < Y_SPAN;
    w_ext_x   = (w_px - XX_LO) < XX_SPAN;
    w_ext_y   = (w_ln - YY_LO) < YY_SPAN;
    w_in_board = w_in_x && w_in_y;
    w_in_wall  = BORDER && w_ext_x && w_ext_y && !w_in_board;
    w_addr     = w_rowbase + w_col;
    w_bx_wrap  = (w_bx == BX_LAST);
    w_bx_nxt   = w_bx_wrap ? '0 : w_bx + 6'd1;
    w_col_nxt  = (w_bx_wrap && w_in_x && (w_col != LAST_COL)) ? w_col + ONE_A : w_col;
    w_ln_nxt   = r_ln + 10'd1;
    w_fy_board = (r_ln - Y_LO) < Y_SPAN;
    w_fy_ext   = (r_ln - YY_LO) < YY_SPAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_prev <= 1'b0;
      r_px      <= '0;
      r_bx      <= '0;
      r_col     <= '0;
    end else begin
      r_de_prev <= de;
      if (w_pix) begin
        r_px  <= w_px + 11'd1;
        r_bx  <= w_bx_nxt;
        r_col <= w_col_nxt;
      end else if (sof || w_fall) begin
        r_px <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ln      <= '0;
      r_by      <= '0;
      r_row     <= '0;
      r_rowbase <= '0;
    end else if (sof) begin
      r_ln      <= '0;
      r_by      <= BY_LD;
      r_row     <= '0;
      r_rowbase <= '0;
    end else if (w_fall) begin
      r_ln <= w_ln_nxt;
      if ((YY_LO != '0) && (w_ln_nxt == YY_LO)) begin
        r_by <= '0;
      end else if (w_fy_ext) begin
        r_by <= (r_by == BY_LAST) ? '0 : r_by + 6'd1;
      end
      if ((Y_LO != '0) && (w_ln_nxt == Y_LO)) begin
        r_row     <= '0;
        r_rowbase <= '0;
      end else if (w_fy_board && (r_by == BY_LAST) && (r_row != LAST_ROW)) begin
        r_row     <= r_row + ONE_A;
        r_rowbase <= r_rowbase + COLS_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_board <= 1'b0;
      r_s1_wall  <= 1'b0;
      r_s1_bx    <= '0;
      r_s1_by    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_board <= 1'b0;
      r_s2_wall  <= 1'b0;
      r_s2_bx    <= '0;
      r_s2_by    <= '0;
    end else begin
      rd_en      <= w_pix && w_in_board;
      if (w_pix && w_in_board) rd_addr <= w_addr;
      r_s1_valid <= w_pix;
      r_s1_board <= w_pix && w_in_board;
      r_s1_wall  <= w_pix && w_in_wall;
      r_s1_bx    <= (w_pix && (w_in_board || w_in_wall)) ? w_bx : '0;
      r_s1_by    <= (w_pix && (w_in_board || w_in_wall)) ? w_by : '0;
      r_s2_valid <= r_s1_valid;
      r_s2_board <= r_s1_board;
      r_s2_wall  <= r_s1_wall;
      r_s2_bx    <= r_s1_bx;
      r_s2_by    <= r_s1_by;
    end
  end

  always_comb begin
    w_map = 12'hFFF;
    unique case (rd_data)
      4'd0:    w_map = 12'h000;
      4'd1:    w_map = 12'h0FF;
      4'd2:    w_map = 12'hFF0;
      4'd3:    w_map = 12'hF0F;
      4'd4:    w_map = 12'h0F0;
      4'd5:    w_map = 12'hF00;
      4'd6:    w_map = 12'h00F;
      4'd7:    w_map = 12'hF80;
      default: w_map = 12'hFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      in_board   <= 1'b0;
      block_x    <= '0;
      block_y    <= '0;
      cell_color <= '0;
    end else begin
      out_valid  <= r_s2_valid;
      in_board   <= r_s2_board || r_s2_wall;
      block_x    <= r_s2_bx;
      block_y    <= r_s2_by;
      cell_color <= r_s2_board ? w_map : (r_s2_wall ? 12'h888 : 12'h000);
    end
  end

endmodule

// File: tb/tb_block_scanner.sv
// Self-checking bench for block_scanner: random raster against a coordinate-arithmetic model.
module tb_block_scanner;
  localparam int CELL_W = 26;
  localparam int CELL_H = 32;
  localparam int COLS   = 10;
  localparam int ROWS   = 15;
  localparam int X0     = 190;
  localparam int Y0     = 0;
  localparam int AW     = 8;

  logic          clk = 1'b0;
  logic          rst_n, sof, de;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [3:0]    rd_data;
  logic [5:0]    block_x, block_y;
  logic [11:0]   cell_color;
  logic          in_board, out_valid;

  block_scanner #(.CELL_W(CELL_W), .CELL_H(CELL_H), .COLS(COLS), .ROWS(ROWS),
                  .X0(X0), .Y0(Y0), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .de(de), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .block_x(block_x), .block_y(block_y), .cell_color(cell_color),
    .in_board(in_board), .out_valid(out_valid));

  always #5 clk = ~clk;

  logic [3:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    bit valid; bit inb; bit board; int px; int ln;
    logic [5:0] bx; logic [5:0] by; logic [AW-1:0] addr; logic [11:0] color; logic [AW-1:0] hold;
  } rec_t;
  typedef struct packed { logic d; logic s; } stim_t;

  rec_t    q[$];
  stim_t   stim[$];
  int      checks = 0, failures = 0;
  bit      m_armed, m_de_prev;
  int      m_px, m_ln;
  logic [AW-1:0] m_hold;

  function automatic logic [11:0] cmap(logic [3:0] c);
    logic [11:0] t [8] = '{12'h000, 12'h0FF, 12'hFF0, 12'hF0F, 12'h0F0, 12'hF00, 12'h00F, 12'hF80};
    return (c > 4'd7) ? 12'hFFF : t[c[2:0]];
  endfunction

  function automatic rec_t model_pixel(int px, int ln);
    rec_t r = '{default: 0};
    bit in_x = (px >= X0) && (px < X0 + COLS * CELL_W);
    bit in_y = (ln >= Y0) && (ln < Y0 + ROWS * CELL_H);
    r.valid = 1; r.px = px; r.ln = ln;
    if (in_x && in_y) begin
      r.board = 1; r.inb = 1;
      r.bx    = 6'((px - X0) % CELL_W);
      r.by    = 6'((ln - Y0) % CELL_H);
      r.addr  = AW'(((ln - Y0) / CELL_H) * COLS + (px - X0) / CELL_W);
      r.color = cmap(mem[r.addr]);
    end
`ifdef BOARD_BORDER_EN
    else if ((px >= X0 - CELL_W) && (px < X0 + (COLS + 1) * CELL_W) &&
             (ln >= Y0 - CELL_H) && (ln < Y0 + (ROWS + 1) * CELL_H)) begin
      r.inb   = 1;
      r.bx    = 6'((px - X0 + CELL_W) % CELL_W);
      r.by    = 6'((ln - Y0 + CELL_H) % CELL_H);
      r.color = 12'h888;
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    rec_t z = '{default: 0};
    m_armed = 0; m_de_prev = 0; m_px = 0; m_ln = 0; m_hold = '0;
    q.delete();
    repeat (3) q.push_back(z);
  endtask

  // eo: record due on the pixel outputs now; er: record due on rd_en/rd_addr now
  task automatic tick(input logic d, input logic s, output rec_t eo, output rec_t er);
    rec_t r;
    @(negedge clk);
    er = q[$];
    eo = q.pop_front();
    if (s) begin m_armed = 1; m_px = 0; m_ln = 0; end
    else if (m_armed && !d && m_de_prev) begin m_px = 0; m_ln++; end
    r = '{default: 0};
    if (m_armed && d) begin
      r = model_pixel(m_px, m_ln);
      if (r.board) m_hold = r.addr;
      m_px++;
    end
    r.hold = m_hold;
    m_de_prev = d;
    q.push_back(r);
    de = d; sof = s;
  endtask

  task automatic add_line(int len, int gap);
    for (int i = 0; i < len; i++) stim.push_back('{d: 1'b1, s: 1'b0});
    for (int i = 0; i < gap; i++) stim.push_back('{d: 1'b0, s: 1'b0});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de = 1'b0; sof = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, out_valid, in_board, block_x, block_y, cell_color} !== '0) begin
      failures++;
      $display("FAIL reset_values got rd_en=%b rd_addr=%0d v=%b ib=%b bx=%0d by=%0d col=%h required all 0",
               rd_en, rd_addr, out_valid, in_board, block_x, block_y, cell_color);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_disarmed();
    rec_t eo, er;
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b0, eo, er);
      checks++;
      if ({out_valid, in_board, block_x, block_y, cell_color, rd_en, rd_addr} !== '0) begin
        failures++;
        $display("FAIL disarmed cyc=%0d got v=%b ib=%b bx=%0d by=%0d col=%h rd_en=%b addr=%0d required all 0",
                 i, out_valid, in_board, block_x, block_y, cell_color, rd_en, rd_addr);
      end
    end
  endtask

  task automatic test_frame();
    rec_t eo, er;
    logic [25:0] got, exp;
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[0] = 4'd3; mem[5] = 4'd0; mem[17] = 4'd0;
    stim.delete();
    stim.push_back('{d: 1'b0, s: 1'b1});
    stim.push_back('{d: 1'b0, s: 1'b0});
    for (int ln = 0; ln < 490; ln++) begin
      int gap = $urandom_range(1, 3);
      if (ln inside {0, 1, 5, 31, 32, 33, 100, 478, 479, 480} || $urandom_range(0, 49) == 0)
        add_line(640, gap);
      else if ($urandom_range(0, 7) == 0)
        add_line($urandom_range(200, 460), gap);
      else
        add_line($urandom_range(1, 6), gap);
    end
    add_line(0, 6);
    foreach (stim[k]) begin
      tick(stim[k].d, stim[k].s, eo, er);
      got = eo.valid ? {out_valid, in_board, block_x, block_y, cell_color} : {out_valid, 25'b0};
      exp = {eo.valid, eo.inb, eo.bx, eo.by, eo.color};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pixel ln=%0d px=%0d got v/ib/bx/by/col=%b/%b/%0d/%0d/%h required %b/%b/%0d/%0d/%h",
                 eo.ln, eo.px, got[25], got[24], got[23:18], got[17:12], got[11:0],
                 exp[25], exp[24], exp[23:18], exp[17:12], exp[11:0]);
      end
      checks++;
      if ({rd_en, rd_addr} !== {er.valid && er.board, er.hold}) begin
        failures++;
        $display("FAIL ram_read ln=%0d px=%0d got rd_en=%b addr=%0d required rd_en=%b addr=%0d",
                 er.ln, er.px, rd_en, rd_addr, er.valid && er.board, er.hold);
      end
      if (eo.valid && eo.ln == 0 && eo.px == 190) begin
        checks++;
        if ({out_valid, block_x, cell_color} !== {1'b1, 6'd0, 12'hF0F}) begin
          failures++;
          $display("FAIL first_cell got v=%b bx=%0d col=%h required v=1 bx=0 col=f0f", out_valid, block_x, cell_color);
        end
      end
      if (eo.valid && eo.ln == 0 && eo.px == 215) begin
        checks++;
        if (block_x !== 6'd25) begin
          failures++; $display("FAIL cell_edge_bx got %0d required 25", block_x);
        end
      end
      if (er.valid && er.ln == 0 && er.px == 216) begin
        checks++;
        if ({rd_en, rd_addr} !== {1'b1, 8'd1}) begin
          failures++; $display("FAIL second_cell_addr got en=%b addr=%0d required en=1 addr=1", rd_en, rd_addr);
        end
      end
      if (er.valid && er.ln == 32 && er.px == 190) begin
        checks++;
        if (rd_addr !== 8'd10) begin
          failures++; $display("FAIL row1_addr got %0d required 10", rd_addr);
        end
      end
      if (eo.valid && eo.ln == 32 && eo.px == 190) begin
        checks++;
        if (block_y !== 6'd0) begin
          failures++; $display("FAIL row1_by got %0d required 0", block_y);
        end
      end
      if (eo.valid && eo.ln == 479 && eo.px == 449) begin
        checks++;
        if ({in_board, block_x, block_y} !== {1'b1, 6'd25, 6'd31}) begin
          failures++;
          $display("FAIL last_pixel got ib=%b bx=%0d by=%0d required ib=1 bx=25 by=31", in_board, block_x, block_y);
        end
      end
      if (er.valid && er.ln == 479 && er.board) begin
        checks++;
        if (!(rd_addr >= 8'd140 && rd_addr <= 8'd149)) begin
          failures++; $display("FAIL last_row_addr px=%0d got %0d required 140..149", er.px, rd_addr);
        end
      end
      if (eo.valid && eo.ln < 480 && eo.px == 450) begin
        checks++;
        if ({in_board, block_x} !== {1'b0, 6'd0}) begin
          failures++; $display("FAIL right_outside got ib=%b bx=%0d required ib=0 bx=0", in_board, block_x);
        end
      end
    end
  endtask

  task automatic test_sof_with_de();
    rec_t eo, er;
    logic [25:0] got, exp;
    stim.delete();
    stim.push_back('{d: 1'b1, s: 1'b1});
    add_line(299, 2);
    add_line(300, 2);
    add_line(280, 6);
    foreach (stim[k]) begin
      tick(stim[k].d, stim[k].s, eo, er);
      got = eo.valid ? {out_valid, in_board, block_x, block_y, cell_color} : {out_valid, 25'b0};
      exp = {eo.valid, eo.inb, eo.bx, eo.by, eo.color};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL sof_de_pixel ln=%0d px=%0d got %h required %h", eo.ln, eo.px, got, exp);
      end
      checks++;
      if ({rd_en, rd_addr} !== {er.valid && er.board, er.hold}) begin
        failures++;
        $display("FAIL sof_de_read ln=%0d px=%0d got en=%b addr=%0d required en=%b addr=%0d",
                 er.ln, er.px, rd_en, rd_addr, er.valid && er.board, er.hold);
      end
    end
  endtask

  task automatic test_reset_midframe();
    rec_t eo, er;
    logic [25:0] got, exp;
    bit strict;
    stim.delete();
    stim.push_back('{d: 1'b0, s: 1'b1});
    add_line(250, 0);
    foreach (stim[k]) tick(stim[k].d, stim[k].s, eo, er);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, rd_addr, out_valid, in_board, block_x, block_y, cell_color} !== '0) begin
      failures++;
      $display("FAIL async_flush got en=%b addr=%0d v=%b ib=%b bx=%0d by=%0d col=%h required all 0",
               rd_en, rd_addr, out_valid, in_board, block_x, block_y, cell_color);
    end
    model_reset();
    stim.delete();
    repeat (3) stim.push_back('{d: 1'b1, s: 1'b0});
    add_line(300, 3);
    add_line(400, 3);
    stim.push_back('{d: 1'b0, s: 1'b1});
    add_line(300, 6);
    strict = 1;
    foreach (stim[k]) begin
      tick(stim[k].d, stim[k].s, eo, er);
      if (k == 2) rst_n = 1'b1;
      if (eo.valid) strict = 0;
      got = (eo.valid || strict) ? {out_valid, in_board, block_x, block_y, cell_color} : {out_valid, 25'b0};
      exp = {eo.valid, eo.inb, eo.bx, eo.by, eo.color};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL post_reset_pixel step=%0d ln=%0d px=%0d got %h required %h", k, eo.ln, eo.px, got, exp);
      end
      checks++;
      if ({rd_en, rd_addr} !== {er.valid && er.board, er.hold}) begin
        failures++;
        $display("FAIL post_reset_read step=%0d got en=%b addr=%0d required en=%b addr=%0d",
                 k, rd_en, rd_addr, er.valid && er.board, er.hold);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_disarmed();
    test_frame();
    test_sof_with_de();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
